// File: rtl/d_latch_sr.sv
// d_latch_sr: clocked emulation of a gated D latch with set and reset.
// All storage is edge-triggered on the rising edge of clk. reset_n is
// synchronous and active low and has the highest priority. set_n is next
// (q goes all ones). Then the gate g decides: g=1 loads d, g=0 holds q.
// q_n is always the bitwise complement of q.
//
// Optional build macro: D_LATCH_SR_SYNC_EN
//   defined   - d, g and set_n each pass through a 2-flop synchronizer.
//               These inputs then take 3 cycles to reach q. reset_n is
//               not synchronized and still acts after 1 cycle.
//   undefined - no synchronizer flops exist; every input acts after 1 cycle.
module d_latch_sr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_n,
    input  logic [WIDTH-1:0] d,
    input  logic             g,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             conflict
);

    // The update logic reads these inputs, either straight from the ports
    // or from the end of the synchronizer chain.
    logic [WIDTH-1:0] d_eff;
    logic             g_eff;
    logic             set_n_eff;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             conflict_reg;

`ifdef D_LATCH_SR_SYNC_EN
    localparam int SYNC_STAGES = 2;

    // One block per synchronizer stage. Stage 0 takes the ports and each
    // later stage takes the stage before it.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync_stage
        logic [WIDTH-1:0] d_in;
        logic             g_in;
        logic             set_n_in;
        logic [WIDTH-1:0] d_reg;
        logic             g_reg;
        logic             set_n_reg;

        if (gi == 0) begin : g_head
            assign d_in     = d;
            assign g_in     = g;
            assign set_n_in = set_n;
        end else begin : g_tail
            assign d_in     = g_sync_stage[gi-1].d_reg;
            assign g_in     = g_sync_stage[gi-1].g_reg;
            assign set_n_in = g_sync_stage[gi-1].set_n_reg;
        end

        // Shift the stage. Reset loads the inactive values (d=0, gate
        // closed, set released) so that no stale set or load is released
        // after reset.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                d_reg     <= '0;
                g_reg     <= 1'b0;
                set_n_reg <= 1'b1;
            end else begin
                d_reg     <= d_in;
                g_reg     <= g_in;
                set_n_reg <= set_n_in;
            end
        end
    end

    assign d_eff     = g_sync_stage[SYNC_STAGES-1].d_reg;
    assign g_eff     = g_sync_stage[SYNC_STAGES-1].g_reg;
    assign set_n_eff = g_sync_stage[SYNC_STAGES-1].set_n_reg;
`else
    assign d_eff     = d;
    assign g_eff     = g;
    assign set_n_eff = set_n;
`endif

    // Next state below reset: set wins over gate, and a closed gate holds.
    // All bits update together.
    always_comb begin
        q_next = q_reg;
        if (!set_n_eff) begin
            q_next = '1;
        end else if (g_eff) begin
            q_next = d_eff;
        end
    end

    // State register. Reset clears q and flags a conflict when set was
    // asserted in the same cycle. The flag clears on any edge without reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_reg        <= '0;
            conflict_reg <= ~set_n_eff;
        end else begin
            q_reg        <= q_next;
            conflict_reg <= 1'b0;
        end
    end

    assign q        = q_reg;
    assign q_n      = ~q_reg;
    assign conflict = conflict_reg;

endmodule

// File: tb/tb_d_latch_sr.sv
// Testbench for d_latch_sr. It drives a WIDTH=1 instance and a WIDTH=8
// instance from one clock. Each step writes its expected q and conflict
// into a scoreboard queue. After the next rising edge the step pops that
// entry and compares it with the DUT outputs, then prints one line.
module tb_d_latch_sr;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       conf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;

    logic       rn1 = 1'b0, sn1 = 1'b1, g1 = 1'b0;
    logic [0:0] d1  = '0;
    logic [0:0] q1, q1_n;
    logic       conf1;

    logic       rn8 = 1'b0, sn8 = 1'b1, g8 = 1'b0;
    logic [7:0] d8  = '0;
    logic [7:0] q8, q8_n;
    logic       conf8;

    always #5 clk = ~clk;

    d_latch_sr #(.WIDTH(1)) dut1 (
        .clk(clk), .reset_n(rn1), .set_n(sn1), .d(d1), .g(g1),
        .q(q1), .q_n(q1_n), .conflict(conf1)
    );

    d_latch_sr #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(rn8), .set_n(sn8), .d(d8), .g(g8),
        .q(q8), .q_n(q8_n), .conflict(conf8)
    );

    // One step on the WIDTH=1 instance. The expected value is pushed when
    // the step is driven and popped after the edge.
    task automatic step1(input logic rn, input logic sn, input logic g,
                         input logic d, input logic eq, input logic econf,
                         input string tag);
        exp_t e;
        logic [0:0] eq1;
        rn1 = rn; sn1 = sn; g1 = g; d1 = d;
        e.tag = tag; e.q = {7'd0, eq}; e.conf = econf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        eq1 = e.q[0:0];
        checks++;
        assert (q1 === eq1) else begin
            errors++;
            $error("FAIL %s q: got %b expected %b", e.tag, q1, eq1);
        end
        checks++;
        assert (q1_n === ~eq1) else begin
            errors++;
            $error("FAIL %s q_n: got %b expected %b", e.tag, q1_n, ~eq1);
        end
        checks++;
        assert (conf1 === e.conf) else begin
            errors++;
            $error("FAIL %s conflict: got %b expected %b", e.tag, conf1, e.conf);
        end
        $display("W1 %-14s rn=%b sn=%b g=%b d=%b -> q=%b q_n=%b conflict=%b",
                 e.tag, rn, sn, g, d, q1, q1_n, conf1);
    endtask

    // One step on the WIDTH=8 instance.
    task automatic step8(input logic rn, input logic sn, input logic g,
                         input logic [7:0] d, input logic [7:0] eq,
                         input logic econf, input string tag);
        exp_t e;
        rn8 = rn; sn8 = sn; g8 = g; d8 = d;
        e.tag = tag; e.q = eq; e.conf = econf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (q8 === e.q) else begin
            errors++;
            $error("FAIL %s q: got %h expected %h", e.tag, q8, e.q);
        end
        checks++;
        assert (q8_n === ~e.q) else begin
            errors++;
            $error("FAIL %s q_n: got %h expected %h", e.tag, q8_n, ~e.q);
        end
        checks++;
        assert (conf8 === e.conf) else begin
            errors++;
            $error("FAIL %s conflict: got %b expected %b", e.tag, conf8, e.conf);
        end
        $display("W8 %-14s rn=%b sn=%b g=%b d=%h -> q=%h q_n=%h conflict=%b",
                 e.tag, rn, sn, g, d, q8, q8_n, conf8);
    endtask

    initial begin
`ifdef D_LATCH_SR_SYNC_EN
        // Inputs pass through 2 synchronizer flops, so a change takes
        // 3 edges to reach q. reset_n still acts on the next edge.
        step1(0, 1, 0, 0, 0, 0, "reset_a");
        step1(0, 1, 0, 0, 0, 0, "reset_b");
        step1(1, 1, 1, 0, 0, 0, "g1_d0_e1");
        step1(1, 1, 1, 0, 0, 0, "g1_d0_e2");
        step1(1, 1, 1, 0, 0, 0, "g1_d0_e3");
        step1(1, 1, 1, 1, 0, 0, "d1_edge1");
        step1(1, 1, 1, 1, 0, 0, "d1_edge2");
        step1(1, 1, 1, 1, 1, 0, "d1_edge3");
        step1(0, 1, 1, 1, 0, 0, "reset_1cyc");
        step8(0, 1, 0, 8'h00, 8'h00, 0, "w8_reset");
        step8(1, 1, 1, 8'h5A, 8'h00, 0, "w8_lat1");
        step8(1, 1, 1, 8'h5A, 8'h00, 0, "w8_lat2");
        step8(1, 1, 1, 8'h5A, 8'h5A, 0, "w8_lat3");
`else
        // Reset with set released gives q=0 and no conflict.
        step1(0, 1, 0, 0, 0, 0, "reset");
        // Set with the gate closed. Releasing set leaves q at 1.
        step1(1, 0, 0, 0, 1, 0, "set_g0");
        step1(1, 1, 0, 1, 1, 0, "set_rel_a");
        step1(1, 1, 0, 1, 1, 0, "set_rel_b");
        step1(1, 1, 0, 0, 1, 0, "set_rel_c");
        // Reset with the gate closed while d toggles. Releasing reset leaves q at 0.
        step1(0, 1, 0, 1, 0, 0, "rst_d1");
        step1(0, 1, 0, 0, 0, 0, "rst_d0");
        step1(0, 1, 0, 1, 0, 0, "rst_d1b");
        step1(1, 1, 0, 1, 0, 0, "rst_rel_a");
        step1(1, 1, 0, 1, 0, 0, "rst_rel_b");
        // Transparent: q follows d one edge later.
        step1(1, 1, 1, 0, 0, 0, "transp_0");
        step1(1, 1, 1, 1, 1, 0, "transp_1");
        step1(1, 1, 1, 0, 0, 0, "transp_2");
        step1(1, 1, 1, 1, 1, 0, "transp_3");
        step1(1, 1, 1, 0, 0, 0, "transp_4");
        // Gate falls in the same cycle that d rises, so q holds 0.
        step1(1, 1, 0, 1, 0, 0, "hold_gfall");
        step1(1, 1, 0, 0, 0, 0, "hold_t1");
        step1(1, 1, 0, 1, 0, 0, "hold_t2");
        // Reset and set together: reset wins and conflict is raised.
        step1(0, 0, 0, 0, 0, 1, "conflict1");
        step1(1, 0, 0, 0, 1, 0, "conf_clear1");
        // WIDTH=8: conflict, then release reset only.
        step8(0, 1, 0, 8'h00, 8'h00, 0, "w8_reset");
        step8(0, 0, 0, 8'h00, 8'h00, 1, "w8_conflict");
        step8(1, 0, 0, 8'h00, 8'hFF, 0, "w8_rel_rst");
        step8(1, 1, 1, 8'hA5, 8'hA5, 0, "w8_load");
        step8(1, 1, 0, 8'h3C, 8'hA5, 0, "w8_hold");
        step8(1, 1, 1, 8'h3C, 8'h3C, 0, "w8_load2");
        step8(0, 1, 1, 8'hFF, 8'h00, 0, "w8_rst_g1");
`endif
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
